// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

    localparam int unsigned DEF_DATA_BITS = 8;
    localparam int unsigned TICKS_PER_BIT = 16;
    localparam int unsigned START_MID     = 7;
    localparam int unsigned TICK_CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs; both flops reset to RESET_VAL.
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q;
    logic sync_q;

    // Two-stage shift to settle metastability before the value is used
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; reports good bytes and framing errors.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned STOP_TICKS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_error
);

    localparam int unsigned NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                  rx_s;
    rx_state_e             state_q;
    logic [TICK_CNT_W-1:0] s_cnt_q;
    logic [NW-1:0]         n_cnt_q;
    logic [DATA_BITS-1:0]  b_q;
    logic [DATA_BITS-1:0]  data_q;
    logic                  rx_done_q;
    logic                  frame_err_q;

    rx_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_rx),
        .o_sync  (rx_s)
    );

    // Frame recovery FSM: start check at mid start bit, data at bit midpoints, stop check last
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            s_cnt_q     <= '0;
            n_cnt_q     <= '0;
            b_q         <= '0;
            data_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Falling edge is taken immediately so the tick phase sets the sample grid
                    if (!rx_s) begin
                        state_q <= ST_START;
                        s_cnt_q <= '0;
                    end
                end
                ST_START: begin
                    if (i_tick) begin
                        if (s_cnt_q == TICK_CNT_W'(START_MID)) begin
                            if (!rx_s) begin
                                state_q <= ST_DATA;
                                s_cnt_q <= '0;
                                n_cnt_q <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + TICK_CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (i_tick) begin
                        if (s_cnt_q == TICK_CNT_W'(TICKS_PER_BIT - 1)) begin
                            s_cnt_q <= '0;
                            b_q     <= {rx_s, b_q[DATA_BITS-1:1]};
                            if (n_cnt_q == NW'(DATA_BITS - 1)) begin
                                state_q <= ST_STOP;
                            end else begin
                                n_cnt_q <= n_cnt_q + NW'(1);
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + TICK_CNT_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (i_tick) begin
                        if (s_cnt_q == TICK_CNT_W'(STOP_TICKS - 1)) begin
                            // Back to IDLE at stop midpoint so an abutting start bit is caught
                            state_q <= ST_IDLE;
                            if (rx_s) begin
                                data_q    <= b_q;
                                rx_done_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + TICK_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_data        = data_q;
    assign o_rx_done     = rx_done_q;
    assign o_frame_error = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued as they are sent and matched on each output pulse.
module tb_uart_rx;

    localparam int unsigned BIT_CYC = 64;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_tick;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_error;

    int         vectors     = 0;
    int         miscompares = 0;
    exp_t       sb_q[$];
    logic [7:0] last_good;
    logic [31:0] asm_word;
    int         asm_cnt;
    int         ready_cnt;
    int         tdiv;

    uart_rx #(
        .DATA_BITS  (8),
        .STOP_TICKS (16)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_tick        (i_tick),
        .i_rx          (i_rx),
        .o_data        (o_data),
        .o_rx_done     (o_rx_done),
        .o_frame_error (o_frame_error)
    );

    always #5 i_clk = ~i_clk;

    // Oversampling tick: one cycle in four
    initial begin
        i_tick = 1'b0;
        tdiv   = 0;
        forever begin
            @(negedge i_clk);
            tdiv   = (tdiv + 1) % 4;
            i_tick = (tdiv == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic drive_bit(input logic b);
        i_rx = b;
        wait_cyc(BIT_CYC);
    endtask

    // Send one frame LSB first; a zero stop bit is released after its midpoint
    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        exp_t e;
        if (stop_b) begin
            e.is_err  = 1'b0;
            e.data    = d;
            last_good = d;
        end else begin
            e.is_err = 1'b1;
            e.data   = last_good;
        end
        sb_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (stop_b) begin
            drive_bit(1'b1);
        end else begin
            i_rx = 1'b0;
            wait_cyc(48);
            i_rx = 1'b1;
            wait_cyc(16);
        end
    endtask

    // Match every output pulse against the scoreboard and model the word assembler downstream
    task automatic monitor();
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_rx_done || o_frame_error) begin
                check("both_flags", 32'(o_rx_done & o_frame_error), 32'h0);
                check("done_spacing", 32'(prev_done & o_rx_done), 32'h0);
                check("pulse_expected", 32'(sb_q.size() > 0), 32'h1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("pulse_kind", 32'(o_frame_error), 32'(e.is_err));
                    check("pulse_data", 32'(o_data), 32'(e.data));
                end
                if (o_rx_done) begin
                    asm_word = {o_data, asm_word[31:8]};
                    asm_cnt++;
                    if (asm_cnt == 4) begin
                        ready_cnt++;
                        asm_cnt = 0;
                    end
                end
            end
            prev_done = o_rx_done;
        end
    endtask

    initial begin
        logic [7:0] abort_byte;
        i_reset   = 1'b0;
        i_rx      = 1'b1;
        last_good = 8'h00;
        asm_word  = '0;
        asm_cnt   = 0;
        ready_cnt = 0;
        wait_cyc(3);
        check("rst_data", 32'(o_data), 32'h0);
        check("rst_done", 32'(o_rx_done), 32'h0);
        check("rst_ferr", 32'(o_frame_error), 32'h0);
        i_reset = 1'b1;
        fork
            monitor();
        join_none
        wait_cyc(20);

        // Start glitch: four ticks low, then high
        i_rx = 1'b0;
        wait_cyc(16);
        i_rx = 1'b1;
        wait_cyc(100);
        check("glitch_data", 32'(o_data), 32'h0);

        send_frame(8'hA5, 1'b1);
        wait_cyc(64);

        // Back-to-back, no idle between stop and next start
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cyc(64);

        send_frame(8'h11, 1'b1);
        wait_cyc(64);
        send_frame(8'h3C, 1'b0);
        wait_cyc(128);
        check("ferr_hold", 32'(o_data), 32'h11);

        // Reset in the middle of data bit 3
        abort_byte = 8'h77;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(abort_byte[i]);
        i_rx = abort_byte[3];
        wait_cyc(32);
        #2;
        i_reset = 1'b0;
        #1;
        check("midrst_data", 32'(o_data), 32'h0);
        check("midrst_done", 32'(o_rx_done), 32'h0);
        check("midrst_ferr", 32'(o_frame_error), 32'h0);
        wait_cyc(4);
        i_rx = 1'b1;
        wait_cyc(4);
        i_reset   = 1'b1;
        last_good = 8'h00;
        wait_cyc(64);
        send_frame(8'h5A, 1'b1);
        wait_cyc(64);
        check("post_rst_data", 32'(o_data), 32'h5A);

        // Four bytes into the downstream word assembler
        asm_word  = '0;
        asm_cnt   = 0;
        ready_cnt = 0;
        send_frame(8'h78, 1'b1);
        wait_cyc(32);
        send_frame(8'h56, 1'b1);
        wait_cyc(32);
        send_frame(8'h34, 1'b1);
        wait_cyc(32);
        send_frame(8'h12, 1'b1);
        wait_cyc(128);
        check("asm_word", asm_word, 32'h12345678);
        check("word_ready", 32'(ready_cnt), 32'h1);

        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver for the debug link: samples the asynchronous `i_rx` line with a 16x oversampling tick and recovers 8N1 frames (LSB first). It sits directly upstream of the debug-unit receive interface. Its `o_data`/`o_rx_done` drive that interface's byte input and data-ready input, which assemble four bytes into a 32-bit word. Framing errors are flagged and never reported as valid bytes.

## Interface
- `DATA_BITS`, 8, number of data bits per frame
- `STOP_TICKS`, 16, oversampling ticks from the last data-bit midpoint to the stop-bit sample
- `i_clk`  in  1  system clock
- `i_reset`  in  1  asynchronous, active-low reset
- `i_tick`  in  1  baud x16 enable, one `i_clk` cycle wide
- `i_rx`  in  1  serial line, idle high, asynchronous to `i_clk`
- `o_data`  out  `DATA_BITS`  last correctly framed byte
- `o_rx_done`  out  1  one-cycle pulse: `o_data` holds a new valid byte
- `o_frame_error`  out  1  one-cycle pulse: stop bit sampled low, byte discarded

## Operation
- **Synchronizer.** `i_rx` passes through 2 flops before use; the synchronized value is `rx_s`. Both flops reset to 1.
- **State machine.** States are IDLE, START, DATA, STOP.
- **Registers.**
  - `s_cnt`: 4-bit tick counter.
  - `n_cnt`: `$clog2(DATA_BITS)` bit counter.
  - `b`: `DATA_BITS`-bit shift register.
- **IDLE.** `rx_s==0` (not gated by tick) -> START, `s_cnt<=0`.
- **START** (advances only on ticks):
  - On a tick with `s_cnt==7`: if `rx_s==0` -> DATA, `s_cnt<=0`, `n_cnt<=0`; otherwise -> IDLE (glitch rejected).
  - Any other tick: `s_cnt++`.
- **DATA** (advances only on ticks):
  - On a tick with `s_cnt==15`: `s_cnt<=0`, `b<={rx_s, b[DATA_BITS-1:1]}`. Then if `n_cnt==DATA_BITS-1` -> STOP, else `n_cnt++`.
  - Any other tick: `s_cnt++`.
- **STOP** (advances only on ticks):
  - On a tick with `s_cnt==STOP_TICKS-1`, state -> IDLE and:
    - if `rx_s==1`: `o_data<=b`, `o_rx_done<=1`;
    - else: `o_frame_error<=1`, `o_data` unchanged.
  - Any other tick: `s_cnt++`.
- **Output defaults.** `o_rx_done` and `o_frame_error` are 0 in every other cycle. `o_data` changes only on a valid stop.
- **Break condition.** A line held low after a framing error re-enters START immediately and repeats the error every frame time. No lockup.
- **Reset.** All state returns to reset values asynchronously, including mid-frame.

## Timing
- **Reset values.**
  - `o_data=0`, `o_rx_done=0`, `o_frame_error=0`.
  - State IDLE; `s_cnt=0`, `n_cnt=0`, `b=0`; synchronizer flops =1.
- **Input latency.** `rx_s` lags `i_rx` by 2 `i_clk` cycles.
- **Sample points.**
  - Start bit: checked at tick 8 after the detected falling edge.
  - Each data bit: sampled 16 ticks after the previous sample, i.e. at the bit midpoint.
  - Stop bit: sampled `STOP_TICKS` ticks after the last data sample.
- **Output timing.** Outputs are registered. `o_rx_done`/`o_frame_error` are high during the cycle following the edge that consumed the final stop tick, for exactly 1 cycle.
- **Frame latency.** Start falling edge to `o_rx_done` = 2 cycles + 8 + 16·`DATA_BITS` + `STOP_TICKS` ticks, i.e. 152 ticks at defaults.
- **Back-to-back frames.** The block returns to IDLE at the stop-bit midpoint, so a start bit immediately following the stop bit (no idle gap) is received.
- **Downstream contract.**
  - `o_rx_done` never asserts on two consecutive cycles; minimum spacing is one frame.
  - `o_data` is stable from the `o_rx_done` cycle until the next `o_rx_done`.
- **Tick loss.** Ticks absent for any number of cycles stall START/DATA/STOP with no state change.

## Structure
- **Shared package `uart_pkg`:**
  - state encoding localparams: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11;
  - `TICKS_PER_BIT=16`;
  - `START_MID=7`;
  - default `DATA_BITS`.
- **Sub-module `rx_sync`:** 2-flop synchronizer with reset value 1. It is shared with any future asynchronous inputs.
- **Tick source.** The tick generator (`baud_rate_gen`) is instantiated at the top level, not inside this block.

## Test plan
- **Valid frame.** Tick every 4 cycles; send frame 0xA5 with stop=1 -> exactly one `o_rx_done` pulse, `o_data=0xA5`, `o_frame_error` never high.
- **Back-to-back frames.** Send 0x00 then 0xFF with no idle between stop and start -> two `o_rx_done` pulses, `o_data` 0x00 then 0xFF.
- **Start glitch.** Drive `i_rx` low for 4 ticks then high -> return to IDLE, no pulse on either flag, `o_data` unchanged (0x00 after reset).
- **Framing error.** Receive 0x11, then 0x3C with stop bit 0 -> one `o_frame_error` pulse, no `o_rx_done`, `o_data` stays 0x11.
- **Reset mid-frame.** Assert `i_reset` low during data bit 3 -> all outputs 0 within the same cycle; after release, frame 0x5A -> `o_data=0x5A`, one done pulse.
- **Integration.** Drive the downstream receive interface with bytes 0x78, 0x56, 0x34, 0x12 -> 4 done pulses, assembled word 0x12345678 with its data-ready asserted once.
